// File: rtl/uart_frame_assembler_if.sv
// Byte-request, bin-write and frame handshake bundle for uart_frame_assembler.
// master = assembler side, slave = reader / buffer / inference-core side.
interface uart_frame_assembler_if #(
   parameter int ADDR_W = 10,
   parameter int BIN_W  = 16
);
   logic              read_signal;
   logic              read_valid;
   logic [7:0]        read_data_AXI;
   logic              bin_wr_en;
   logic [ADDR_W-1:0] bin_wr_addr;
   logic [BIN_W-1:0]  bin_wr_data;
   logic              frame_ready;
   logic              frame_ack;
   logic              frame_err;

   modport master (
      output read_signal, bin_wr_en, bin_wr_addr, bin_wr_data, frame_ready, frame_err,
      input  read_valid, read_data_AXI, frame_ack
   );

   modport slave (
      input  read_signal, bin_wr_en, bin_wr_addr, bin_wr_data, frame_ready, frame_err,
      output read_valid, read_data_AXI, frame_ack
   );
endinterface

// File: rtl/uart_frame_assembler.sv
// Hunts SYNC_BYTE, packs little-endian byte pairs into bins and hands the frame to the core.
// Define UART_FRAME_CHECKSUM_EN to add a trailing XOR checksum byte (CHK state).
//
// state | meaning
// IDLE  | one-cycle pause after reset or ack before hunting
// SYNC  | requesting bytes until SYNC_BYTE is seen
// LO    | waiting for the low byte of the current bin
// HI    | waiting for the high byte; the bin is written the cycle after it arrives
// CHK   | waiting for the trailing checksum byte (checksum build only)
// DONE  | frame_ready held until frame_ack
module uart_frame_assembler #(
   parameter int         NUM_BINS  = 1024,
   parameter int         ADDR_W    = 10,
   parameter int         BIN_W     = 16,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 100000
) (
   input logic                     clk,
   input logic                     rst,
   uart_frame_assembler_if.master  fa_if
);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SYNC = 3'd1;
   localparam logic [2:0] S_LO   = 3'd2;
   localparam logic [2:0] S_HI   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd5;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam logic [2:0] S_CHK  = 3'd4;
`endif
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        lo_q, lo_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              pend_q, pend_d;
   logic              rs_q, rs_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [BIN_W-1:0]  wr_data_q, wr_data_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif
   logic              outstanding, take, timed, expire;
   logic [7:0]        byte_in;

   assign byte_in = fa_if.read_data_AXI;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lo_d      = lo_q;
      tmo_d     = tmo_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rdy_d     = rdy_q;
      rs_d      = 1'b0;
      wr_en_d   = 1'b0;
      err_d     = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      // A request is live from its pulse until the matching read_valid.
      outstanding = rs_q | pend_q;
      take        = fa_if.read_valid & outstanding;
      pend_d      = outstanding & ~take;

      timed = (state_q == S_LO) || (state_q == S_HI);
`ifdef UART_FRAME_CHECKSUM_EN
      if (state_q == S_CHK) timed = 1'b1;
`endif
      if (fa_if.read_valid)
         tmo_d = TMO_W'(TIMEOUT - 1);
      else if (timed && tmo_q != '0)
         tmo_d = tmo_q - 1'b1;
      expire = timed && !fa_if.read_valid && (tmo_q == '0);

      case (state_q)
         S_IDLE: begin
            state_d = S_SYNC;
            rs_d    = 1'b1;
         end
         S_SYNC: if (take) begin
            rs_d = 1'b1;
            if (byte_in == SYNC_BYTE) begin
               state_d = S_LO;
               idx_d   = '0;
`ifdef UART_FRAME_CHECKSUM_EN
               csum_d  = '0;
`endif
            end
         end
         S_LO: if (take) begin
            lo_d    = byte_in;
            state_d = S_HI;
            rs_d    = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_d  = csum_q ^ byte_in;
`endif
         end
         S_HI: if (take) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = BIN_W'({byte_in, lo_q});
            idx_d     = idx_q + 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_d    = csum_q ^ byte_in;
`endif
            if (idx_q == LAST_IDX) begin
`ifdef UART_FRAME_CHECKSUM_EN
               state_d = S_CHK;
               rs_d    = 1'b1;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_LO;
               rs_d    = 1'b1;
            end
         end
`ifdef UART_FRAME_CHECKSUM_EN
         S_CHK: if (take) begin
            if (byte_in == csum_q) begin
               state_d = S_DONE;
               rdy_d   = 1'b1;
            end else begin
               state_d = S_SYNC;
               err_d   = 1'b1;
               rs_d    = 1'b1;
            end
         end
`endif
         S_DONE: begin
            if (rdy_q && fa_if.frame_ack) begin
               rdy_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               rdy_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abandon the partial frame; the stale request is dropped and a fresh one issued.
      if (expire) begin
         state_d = S_SYNC;
         err_d   = 1'b1;
         rs_d    = 1'b1;
         pend_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         lo_q      <= '0;
         tmo_q     <= '0;
         pend_q    <= 1'b0;
         rs_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rdy_q     <= 1'b0;
         err_q     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lo_q      <= lo_d;
         tmo_q     <= tmo_d;
         pend_q    <= pend_d;
         rs_q      <= rs_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rdy_q     <= rdy_d;
         err_q     <= err_d;
`ifdef UART_FRAME_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign fa_if.read_signal = rs_q;
   assign fa_if.bin_wr_en   = wr_en_q;
   assign fa_if.bin_wr_addr = wr_addr_q;
   assign fa_if.bin_wr_data = wr_data_q;
   assign fa_if.frame_ready = rdy_q;
   assign fa_if.frame_err   = err_q;
endmodule
